// File: rtl/pipelined_ext_adder_pkg.sv
// Package pipe_adder_pkg: shared helpers for the pipelined extend-and-add block.
//   nseg()       number of carry segments (pipeline stages) for a given width
//   seg_w()      width of segment k; only the top segment may be short
//   stage_ctrl_t per-transaction control captured at the input
package pipe_adder_pkg;

  typedef struct packed {
    logic valid;
    logic b_sext;
  } stage_ctrl_t;

  function automatic int nseg(input int a_w, input int sw);
    return (a_w + sw - 32'sd1) / sw;
  endfunction

  function automatic int seg_w(input int k, input int a_w, input int sw);
    if (k < nseg(a_w, sw) - 32'sd1) begin
      return sw;
    end else begin
      return a_w - (nseg(a_w, sw) - 32'sd1) * sw;
    end
  endfunction

endpackage

// File: rtl/pipelined_ext_adder_if.sv
// Handshake bundle for pipelined_ext_adder.
//   in_valid/in_ready/in_a/in_b/in_b_sext : input transaction
//   in_cin                                : carry-in, only with PIPE_EXT_ADDER_CIN_EN
//   out_valid/out_ready/out_sum           : result transaction (A_W+1 bits)
// master = producer/consumer side, slave = the adder.
interface pipelined_ext_adder_if #(
  parameter int A_W = 49,
  parameter int B_W = 17
);
  logic           in_valid;
  logic           in_ready;
  logic [A_W-1:0] in_a;
  logic [B_W-1:0] in_b;
  logic           in_b_sext;
`ifdef PIPE_EXT_ADDER_CIN_EN
  logic           in_cin;
`endif
  logic           out_valid;
  logic           out_ready;
  logic [A_W:0]   out_sum;

  modport master (
    output in_valid, in_a, in_b, in_b_sext, out_ready,
`ifdef PIPE_EXT_ADDER_CIN_EN
    output in_cin,
`endif
    input  in_ready, out_valid, out_sum
  );

  modport slave (
    input  in_valid, in_a, in_b, in_b_sext, out_ready,
`ifdef PIPE_EXT_ADDER_CIN_EN
    input  in_cin,
`endif
    output in_ready, out_valid, out_sum
  );
endinterface

// File: rtl/pipelined_ext_adder_seg.sv
// adder_seg: one carry segment of the pipelined adder.
//   clk, rst_n  clock, synchronous active-low reset
//   en          stage advance; registers hold when low
//   a, b, cin   segment operands and incoming carry
//   sum_q       registered segment sum
//   cout_q      registered carry out, consumed by the next stage
module adder_seg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum_q,
  output logic         cout_q
);
  logic [W:0]   full_s;
  logic [W-1:0] sum_d;
  logic         cout_d;

  // Segment add with carry-in; hold the registered result while stalled.
  always_comb begin
    full_s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    if (en) begin
      sum_d  = full_s[W-1:0];
      cout_d = full_s[W];
    end else begin
      sum_d  = sum_q;
      cout_d = cout_q;
    end
  end

  // Segment result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q  <= {W{1'b0}};
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end
endmodule

// File: rtl/pipelined_ext_adder.sv
// pipelined_ext_adder: out_sum = {carry, in_a + ext(in_b)} with the carry chain
// cut into SEG_W-bit segments, one pipeline stage per segment.
//   clk    rising-edge clock
//   rst_n  synchronous reset, active low; discards everything in flight
//   bus    pipelined_ext_adder_if.slave (valid/ready in, valid/ready out)
// Optional macro PIPE_EXT_ADDER_CIN_EN adds bus.in_cin as the stage-0 carry-in.
// Stage k adds segment k; operand bits of higher segments ride forward in the
// g_fwd registers and finished low segments ride forward in g_lo so that the
// last stage presents the complete sum. Whole pipeline stalls together.
module pipelined_ext_adder
  import pipe_adder_pkg::*;
#(
  parameter int A_W   = 49,
  parameter int B_W   = 17,
  parameter int SEG_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipelined_ext_adder_if.slave bus
);
  localparam int NSEG = nseg(A_W, SEG_W);

  logic            advance_s;
  logic            in_ready_s;
  logic            cin0_s;
  logic [A_W-1:0]  b_ext_s;
  stage_ctrl_t     in_ctrl_s;
  logic [NSEG-1:0] vld_d, vld_q;

  assign advance_s  = bus.out_ready | ~vld_q[NSEG-1];
  // Reset overrides the stall so the producer sees ready while reset is held.
  assign in_ready_s = advance_s | ~rst_n;

  assign in_ctrl_s.valid  = bus.in_valid & in_ready_s;
  assign in_ctrl_s.b_sext = bus.in_b_sext;

  if (B_W == A_W) begin : g_noext
    assign b_ext_s = bus.in_b;
  end else begin : g_ext
    assign b_ext_s = {{(A_W-B_W){in_ctrl_s.b_sext & bus.in_b[B_W-1]}}, bus.in_b};
  end

`ifdef PIPE_EXT_ADDER_CIN_EN
  assign cin0_s = bus.in_cin;
`else
  assign cin0_s = 1'b0;
`endif

  // Valid chain: shift on advance, bubbles enter as valid = 0.
  always_comb begin
    if (advance_s) begin
      vld_d = NSEG'({vld_q, in_ctrl_s.valid});
    end else begin
      vld_d = vld_q;
    end
  end

  // Valid chain register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= {NSEG{1'b0}};
    end else begin
      vld_q <= vld_d;
    end
  end

  // Operand skew: stage k keeps the bits above its own segment for later stages.
  for (genvar k = 0; k < NSEG - 1; k++) begin : g_fwd
    localparam int HI  = (k + 1) * SEG_W;
    localparam int REM = A_W - HI;
    logic [REM-1:0] a_src_s, b_src_s, a_d, b_d, a_q, b_q;

    if (k == 0) begin : g_first
      assign a_src_s = bus.in_a[A_W-1:HI];
      assign b_src_s = b_ext_s[A_W-1:HI];
    end else begin : g_next
      assign a_src_s = g_fwd[k-1].a_q[REM+SEG_W-1:SEG_W];
      assign b_src_s = g_fwd[k-1].b_q[REM+SEG_W-1:SEG_W];
    end

    // Forward operands on advance, hold otherwise.
    always_comb begin
      if (advance_s) begin
        a_d = a_src_s;
        b_d = b_src_s;
      end else begin
        a_d = a_q;
        b_d = b_q;
      end
    end

    // Operand skew register.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        a_q <= {REM{1'b0}};
        b_q <= {REM{1'b0}};
      end else begin
        a_q <= a_d;
        b_q <= b_d;
      end
    end
  end

  // Segment adders; stage k takes the carry registered by stage k-1.
  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    localparam int W = seg_w(k, A_W, SEG_W);
    logic [W-1:0] a_s, b_s, sum_q;
    logic         cin_s, cout_q;

    if (k == 0) begin : g_first
      assign a_s   = bus.in_a[W-1:0];
      assign b_s   = b_ext_s[W-1:0];
      assign cin_s = cin0_s;
    end else begin : g_next
      assign a_s   = g_fwd[k-1].a_q[W-1:0];
      assign b_s   = g_fwd[k-1].b_q[W-1:0];
      assign cin_s = g_seg[k-1].cout_q;
    end

    adder_seg #(.W(W)) u_seg (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (advance_s),
      .a      (a_s),
      .b      (b_s),
      .cin    (cin_s),
      .sum_q  (sum_q),
      .cout_q (cout_q)
    );
  end

  // Result skew: stage k carries the finished low k segments alongside its own.
  for (genvar k = 1; k < NSEG; k++) begin : g_lo
    localparam int LO = k * SEG_W;
    logic [LO-1:0] src_s, lo_d, lo_q;

    if (k == 1) begin : g_first
      assign src_s = g_seg[0].sum_q;
    end else begin : g_next
      assign src_s = {g_seg[k-1].sum_q, g_lo[k-1].lo_q};
    end

    // Forward finished sums on advance, hold otherwise.
    always_comb begin
      if (advance_s) begin
        lo_d = src_s;
      end else begin
        lo_d = lo_q;
      end
    end

    // Low-sum skew register.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        lo_q <= {LO{1'b0}};
      end else begin
        lo_q <= lo_d;
      end
    end
  end

  if (NSEG == 1) begin : g_out_single
    assign bus.out_sum = {g_seg[0].cout_q, g_seg[0].sum_q};
  end else begin : g_out_multi
    assign bus.out_sum = {g_seg[NSEG-1].cout_q, g_seg[NSEG-1].sum_q, g_lo[NSEG-1].lo_q};
  end

  assign bus.out_valid = vld_q[NSEG-1];
  assign bus.in_ready  = in_ready_s;
endmodule
